// File: rtl/meas_report_pkg.sv
// rtl/meas_report_pkg.sv - shared constants, state type and byte mux for the measurement report packer
//
// Purpose : frame geometry, field byte offsets, packer FSM states and the
//           helper that selects one frame byte from the latched result.
// Ports   : none (package).

package meas_report_pkg;

  localparam int FRAME_LEN = 14;
  localparam int HDR_BYTES = 2;

  // First byte of each field within the frame (big-endian fields)
  localparam int IDX_FREQ = 2;
  localparam int IDX_DUTY = 6;
  localparam int IDX_HIGH = 7;
  localparam int IDX_LOW  = 10;
  localparam int IDX_CSUM = 13;

  // Result record: {freq[25:0], duty[7:0], high[19:0], low[19:0]}
  localparam int REC_W = 74;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } pack_state_t;

  // Flattens the frame MSB-first so byte 0 sits in the top 8 bits, then
  // picks byte idx. Indices past the frame return 0.
  function automatic logic [7:0] frame_byte(input logic [15:0]      hdr,
                                            input logic [REC_W-1:0] rec,
                                            input logic [7:0]       csum,
                                            input logic [3:0]       idx);
    logic [8*FRAME_LEN-1:0] flat;
    flat = {hdr,
            6'b0, rec[73:48],
            rec[47:40],
            4'b0, rec[39:20],
            4'b0, rec[19:0],
            csum};
    if (idx > 4'(FRAME_LEN - 1)) begin
      return 8'h00;
    end
    return flat[8*(FRAME_LEN - 1 - int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/meas_trig_gen.sv
// rtl/meas_trig_gen.sv - start pulse generator for the measurement block
//
// Purpose : merges a software trigger with a periodic auto-trigger and gates
//           the result with the measurement block's busy flag.
// Ports   : clk, rst_n       - clock, asynchronous active-low reset
//           sw_trig          - single-cycle software request
//           auto_en          - level, enables the periodic timer
//           meas_busy        - measurement in progress, triggers ignored
//           meas_enable      - registered one-cycle start pulse

module meas_trig_gen #(
  parameter int unsigned AUTO_INTERVAL = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_trig,
  input  logic auto_en,
  input  logic meas_busy,
  output logic meas_enable
);

  localparam logic [31:0] TIMER_LAST = 32'(AUTO_INTERVAL - 1);

  logic [31:0] timer;
  logic        expire;

  assign expire = auto_en && (timer == TIMER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer       <= '0;
      meas_enable <= 1'b0;
    end else begin
      // Timer is parked at 0 while disabled so enabling always starts a full period.
      if (!auto_en || expire) begin
        timer <= '0;
      end else begin
        timer <= timer + 32'd1;
      end
      // OR of both sources collapses a coincident request into one pulse;
      // requests seen while busy are dropped, not queued.
      meas_enable <= (sw_trig || expire) && !meas_busy;
    end
  end

endmodule

// File: rtl/measure_report_packer.sv
// rtl/measure_report_packer.sv - latches measurement results and streams them as 14-byte frames
//
// Purpose : captures each finished measurement into a pending slot, serialises
//           it as {hdr, freq, duty, high, low, checksum} on a valid/ready byte
//           stream, and drives the measurement start pulse.
// Ports   : clk, rst_n                   - clock, asynchronous active-low reset
//           sw_trig, auto_en, meas_busy  - trigger sources and busy gate
//           meas_finish, meas_freq, meas_duty, meas_high, meas_low - result in
//           meas_enable                  - one-cycle start pulse out
//           tx_data, tx_valid, tx_ready  - byte stream to the UART TX stage
//           frame_busy                   - frame in flight or pending
//           drop_pulse                   - pending result overwritten this cycle

module measure_report_packer
  import meas_report_pkg::*;
#(
  parameter int          CLK_FREQ      = 50_000_000,
  parameter int unsigned AUTO_INTERVAL = 5_000_000,
  parameter logic [15:0] SYNC_HDR      = 16'hA55A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sw_trig,
  input  logic        auto_en,
  input  logic        meas_busy,
  input  logic        meas_finish,
  input  logic [25:0] meas_freq,
  input  logic [7:0]  meas_duty,
  input  logic [19:0] meas_high,
  input  logic [19:0] meas_low,
  output logic        meas_enable,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        frame_busy,
  output logic        drop_pulse
);

  pack_state_t      state, state_nx;
  logic             pend_valid;
  logic [REC_W-1:0] pend_rec;
  logic [REC_W-1:0] frame_rec;
  logic [3:0]       idx;
  logic [7:0]       csum;
  logic             accept;
  logic             last_byte;

  meas_trig_gen #(
    .AUTO_INTERVAL(AUTO_INTERVAL)
  ) u_trig (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_trig    (sw_trig),
    .auto_en    (auto_en),
    .meas_busy  (meas_busy),
    .meas_enable(meas_enable)
  );

  assign tx_valid   = (state == ST_SEND);
  assign tx_data    = tx_valid ? frame_byte(SYNC_HDR, frame_rec, csum, idx) : 8'h00;
  assign accept     = tx_valid && tx_ready;
  assign last_byte  = (idx == 4'(FRAME_LEN - 1));
  assign frame_busy = (state != ST_IDLE) || pend_valid;
  // In LOAD the old pending result is being consumed, so a new one is not a loss.
  assign drop_pulse = meas_finish && pend_valid && (state != ST_LOAD);

  // Pending slot: a finish always wins over the clear in LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_rec   <= '0;
    end else if (meas_finish) begin
      pend_valid <= 1'b1;
      pend_rec   <= {meas_freq, meas_duty, meas_high, meas_low};
    end else if (state == ST_LOAD) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (pend_valid) state_nx = ST_LOAD;
      ST_LOAD: state_nx = ST_SEND;
      ST_SEND: if (accept && last_byte) state_nx = ST_DONE;
      ST_DONE: state_nx = pend_valid ? ST_LOAD : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Frame datapath; the in-flight frame only ever reads frame_rec.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_rec <= '0;
      idx       <= '0;
      csum      <= '0;
    end else if (state == ST_LOAD) begin
      frame_rec <= pend_rec;
      idx       <= '0;
      csum      <= '0;
    end else if (accept) begin
      idx <= idx + 4'd1;
      // Payload bytes only: header and the checksum byte itself are excluded.
      if (idx >= 4'(IDX_FREQ) && idx < 4'(IDX_CSUM)) begin
        csum <= csum + tx_data;
      end
    end
  end

endmodule

// File: tb/tb_measure_report_packer.sv
// tb/tb_measure_report_packer.sv - self-checking bench for measure_report_packer

module tb_measure_report_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw_trig, auto_en, meas_busy, meas_finish;
  logic [25:0] meas_freq;
  logic [7:0]  meas_duty;
  logic [19:0] meas_high, meas_low;
  logic        meas_enable;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        frame_busy;
  logic        drop_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drop_cnt = 0;
  int rdy_mode = 0;
  logic [7:0] byte_q[$];
  int         en_q[$];

  typedef struct {
    logic [25:0]  freq;
    logic [7:0]   duty;
    logic [19:0]  high;
    logic [19:0]  low;
    logic [111:0] exp;
  } vec_t;
  vec_t vecs[4];

  measure_report_packer #(
    .CLK_FREQ     (50_000_000),
    .AUTO_INTERVAL(100),
    .SYNC_HDR     (16'hA55A)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_trig    (sw_trig),
    .auto_en    (auto_en),
    .meas_busy  (meas_busy),
    .meas_finish(meas_finish),
    .meas_freq  (meas_freq),
    .meas_duty  (meas_duty),
    .meas_high  (meas_high),
    .meas_low   (meas_low),
    .meas_enable(meas_enable),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .frame_busy (frame_busy),
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sink readiness: held high or randomly toggled.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) tx_ready = 1'($urandom_range(0, 1));
      else               tx_ready = 1'b1;
    end
  end

  // Stream monitor: collects accepted bytes, checks stall stability,
  // counts drop pulses and logs start-pulse cycles.
  initial begin
    logic       stall_prev;
    logic [7:0] stall_data;
    stall_prev = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (!tx_valid || tx_data !== stall_data) begin
            errors++;
            $display("FAIL stall_hold valid=%0b data=%h required valid=1 data=%h", tx_valid, tx_data, stall_data);
          end
        end
        if (tx_valid && tx_ready) byte_q.push_back(tx_data);
        stall_prev = tx_valid && !tx_ready;
        stall_data = tx_data;
        if (drop_pulse) drop_cnt++;
        if (meas_enable) en_q.push_back(cyc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (frame_busy && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check({name, "_idle_timeout"}, 32'(frame_busy), 32'd0);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  // Reference frame built byte by byte from the field values.
  function automatic logic [111:0] model_frame(input int unsigned f, input int unsigned d,
                                               input int unsigned h, input int unsigned l);
    logic [7:0]   b[14];
    int unsigned  sum;
    logic [111:0] r;
    b[0] = 8'hA5;
    b[1] = 8'h5A;
    for (int i = 0; i < 4; i++) b[2 + i]  = 8'((f >> (8 * (3 - i))) % 256);
    b[6] = 8'(d % 256);
    for (int i = 0; i < 3; i++) b[7 + i]  = 8'((h >> (8 * (2 - i))) % 256);
    for (int i = 0; i < 3; i++) b[10 + i] = 8'((l >> (8 * (2 - i))) % 256);
    sum = 0;
    for (int i = 2; i <= 12; i++) sum += b[i];
    b[13] = 8'(sum % 256);
    r = '0;
    for (int i = 0; i < 14; i++) r[111 - 8*i -: 8] = b[i];
    return r;
  endfunction

  task automatic expect_frame(input string name, input logic [111:0] exp);
    int waited = 0;
    while (byte_q.size() < 14 && waited < 3000) begin
      step();
      waited++;
    end
    check({name, "_frame_complete"}, 32'(byte_q.size() >= 14), 32'd1);
    if (byte_q.size() < 14) begin
      byte_q.delete();
      return;
    end
    for (int i = 0; i < 14; i++) begin
      logic [7:0] got;
      got = byte_q.pop_front();
      check($sformatf("%s_byte%0d", name, i), 32'(got), 32'(exp[111 - 8*i -: 8]));
    end
  endtask

  task automatic drive_result(input logic [25:0] f, input logic [7:0] d,
                              input logic [19:0] h, input logic [19:0] l);
    meas_freq = f; meas_duty = d; meas_high = h; meas_low = l;
  endtask

  task automatic pulse_finish(input logic [25:0] f, input logic [7:0] d,
                              input logic [19:0] h, input logic [19:0] l);
    drive_result(f, d, h, l);
    meas_finish = 1'b1;
    step();
    meas_finish = 1'b0;
  endtask

  initial begin
    int lat;
    int c1;
    int start;
    int drop_before;

    vecs[0] = '{26'd500000,   8'd40,  20'd40,      20'd60,      112'hA55A_0007A120_28_000028_00003C_54};
    vecs[1] = '{26'd1000000,  8'd50,  20'd25,      20'd25,      112'hA55A_000F4240_32_000019_000019_F5};
    vecs[2] = '{26'h3FFFFFF,  8'd100, 20'hFFFFF,   20'hFFFFF,   112'hA55A_03FFFFFF_64_0FFFFF_0FFFFF_7E};
    vecs[3] = '{26'd0,        8'd0,   20'd0,       20'd0,       112'hA55A_00000000_00_000000_000000_00};

    rst_n = 1'b0;
    sw_trig = 1'b0; auto_en = 1'b0; meas_busy = 1'b0; meas_finish = 1'b0;
    drive_result('0, '0, '0, '0);
    repeat (3) step();
    check("rst_tx_valid",    32'(tx_valid),    32'd0);
    check("rst_tx_data",     32'(tx_data),     32'd0);
    check("rst_frame_busy",  32'(frame_busy),  32'd0);
    check("rst_meas_enable", 32'(meas_enable), 32'd0);
    check("rst_drop_pulse",  32'(drop_pulse),  32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Table vectors with tx_ready held high, including finish-to-valid latency.
    for (int v = 0; v < 4; v++) begin
      wait_idle($sformatf("vec%0d", v));
      drive_result(vecs[v].freq, vecs[v].duty, vecs[v].high, vecs[v].low);
      meas_finish = 1'b1;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        step();
        if (k == 1) begin
          meas_finish = 1'b0;
          check($sformatf("vec%0d_busy_after_finish", v), 32'(frame_busy), 32'd1);
        end
        if (tx_valid) begin
          lat = k;
          break;
        end
      end
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'd3);
      expect_frame($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Backpressure on the first vector.
    wait_idle("bp");
    rdy_mode = 1;
    pulse_finish(vecs[0].freq, vecs[0].duty, vecs[0].high, vecs[0].low);
    expect_frame("backpressure", vecs[0].exp);
    rdy_mode = 0;
    repeat (3) step();
    check("bp_no_extra_bytes", 32'(byte_q.size()), 32'd0);

    // Overwrite: two finishes during SEND, only the later one survives.
    wait_idle("ovw");
    drop_before = drop_cnt;
    pulse_finish(vecs[1].freq, vecs[1].duty, vecs[1].high, vecs[1].low);
    for (int k = 0; k < 10 && !tx_valid; k++) step();
    step(); step();
    pulse_finish(26'd1, 8'd50, 20'd25, 20'd25);
    step();
    pulse_finish(26'd2, 8'd50, 20'd25, 20'd25);
    expect_frame("ovw_first", vecs[1].exp);
    expect_frame("ovw_second", model_frame(2, 50, 25, 25));
    repeat (40) step();
    check("ovw_drop_count", 32'(drop_cnt - drop_before), 32'd1);
    check("ovw_no_third_frame", 32'(byte_q.size()), 32'd0);
    check("ovw_idle", 32'(frame_busy), 32'd0);

    // Randomised frames against the reference model, random backpressure.
    rdy_mode = 1;
    for (int n = 0; n < 15; n++) begin
      logic [25:0] f;
      logic [7:0]  d;
      logic [19:0] h, l;
      f = 26'($urandom);
      d = 8'($urandom_range(0, 100));
      h = 20'($urandom);
      l = 20'($urandom);
      wait_idle("rnd");
      repeat ($urandom_range(0, 4)) step();
      pulse_finish(f, d, h, l);
      expect_frame($sformatf("rnd%0d", n), model_frame(f, d, h, l));
    end
    rdy_mode = 0;

    // Asynchronous reset while byte 6 is on the bus.
    wait_idle("rst");
    pulse_finish(vecs[2].freq, vecs[2].duty, vecs[2].high, vecs[2].low);
    for (int k = 0; k < 50 && byte_q.size() < 6; k++) step();
    check("midrst_at_byte6", 32'(byte_q.size()), 32'd6);
    check("midrst_valid_before", 32'(tx_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_valid",    32'(tx_valid),    32'd0);
    check("midrst_frame_busy",  32'(frame_busy),  32'd0);
    check("midrst_meas_enable", 32'(meas_enable), 32'd0);
    repeat (3) step();
    byte_q.delete();
    rst_n = 1'b1;
    repeat (30) step();
    check("postrst_no_bytes",   32'(byte_q.size()), 32'd0);
    check("postrst_tx_valid",   32'(tx_valid),      32'd0);
    check("postrst_frame_busy", 32'(frame_busy),    32'd0);

    // Triggers: period, standalone sw_trig, coincident sw_trig, busy gating.
    en_q.delete();
    start = cyc;
    auto_en = 1'b1;
    for (int k = 0; k < 300 && en_q.size() == 0; k++) step();
    check("trig_first_seen", 32'(en_q.size()), 32'd1);
    c1 = (en_q.size() > 0) ? en_q[0] : start + 100;
    check("trig_first_period", 32'(c1 - start), 32'd100);
    wait_cyc(c1 + 49);
    sw_trig = 1'b1; step(); sw_trig = 1'b0;
    wait_cyc(c1 + 99);
    sw_trig = 1'b1; step(); sw_trig = 1'b0;
    wait_cyc(c1 + 190);
    meas_busy = 1'b1;
    wait_cyc(c1 + 195);
    sw_trig = 1'b1; step(); sw_trig = 1'b0;
    wait_cyc(c1 + 210);
    meas_busy = 1'b0;
    wait_cyc(c1 + 305);
    auto_en = 1'b0;
    repeat (150) step();
    check("trig_pulse_count", 32'(en_q.size()), 32'd4);
    if (en_q.size() == 4) begin
      check("trig_sw_alone",   32'(en_q[1] - c1), 32'd50);
      check("trig_coincident", 32'(en_q[2] - c1), 32'd100);
      check("trig_after_busy", 32'(en_q[3] - c1), 32'd300);
    end

    check("total_drops", 32'(drop_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cycles=%0d required_finish_before_limit", cyc);
    $fatal(1);
  end

endmodule
